// File: rtl/top_pkg.sv
// top_pkg: shared arbiter state type, burst default and counter sizing helper
package top_pkg;
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_e;
   localparam int MAX_BURST_DEF = 16;
   // beat counter must hold max_burst, never narrower than 3 bits
   function automatic int cnt_w(input int max_burst);
      return ($clog2(max_burst + 1) > 3) ? $clog2(max_burst + 1) : 3;
   endfunction
endpackage

// File: rtl/top_rr_pick.sv
// top_rr_pick: combinational round-robin pick, first request at or above ptr_i with wrap
//   req_i  : request vector
//   ptr_i  : index where the search starts
//   gnt_o  : one-hot winner, zero when no request
module top_rr_pick #(
   parameter int num_req_p = 4,
   parameter int idx_w_p = 2
) (
   input  logic [num_req_p-1:0] req_i,
   input  logic [idx_w_p-1:0]   ptr_i,
   output logic [num_req_p-1:0] gnt_o
);
   logic [num_req_p-1:0] rot, pick;
   // rotate so ptr_i lands at bit 0, keep the lowest set bit, rotate back
   always_comb begin
      rot = num_req_p'({req_i, req_i} >> ptr_i);
      pick = rot & (~rot + 1'b1);
      gnt_o = num_req_p'(({pick, pick} << ptr_i) >> num_req_p);
   end
endmodule

// File: rtl/top_key_arb.sv
// top_key_arb: round-robin burst arbiter merging requesters into one registered key stream
//   main_clk_i, main_rst_i     : clock, synchronous active-high reset
//   req_valid_i/accept_o/data_i/last_i : per-requester beat handshake
//   key_valid_o/accept_i/data_o         : shared output stream from the output register
//   grant_o : one-hot owner (zero when idle), busy_o : grant held or output register full
module top_key_arb
   import top_pkg::*;
#(
   parameter int num_req_p = 4,
   parameter int width_p = 9,
   parameter int max_burst_p = MAX_BURST_DEF
) (
   input  logic                 main_clk_i,
   input  logic                 main_rst_i,
   input  logic [num_req_p-1:0] req_valid_i,
   output logic [num_req_p-1:0] req_accept_o,
   input  logic [width_p-1:0]   req_data_i [0:num_req_p-1],
   input  logic [num_req_p-1:0] req_last_i,
   output logic                 key_valid_o,
   input  logic                 key_accept_i,
   output logic [width_p-1:0]   key_data_o,
   output logic [num_req_p-1:0] grant_o,
   output logic                 busy_o
);
   localparam int idx_w = $clog2(num_req_p);
   localparam int cnt_wl = cnt_w(max_burst_p);
   state_e state_q, state_d;
   logic [num_req_p-1:0] grant_q, grant_d, pick;
   logic [idx_w-1:0] ptr_q, ptr_d, gidx;
   logic [cnt_wl-1:0] cnt_q, cnt_d;
   logic kv_q, kv_d;
   logic [width_p-1:0] kd_q, kd_d, sel_data;
   logic xfer, last_beat, done;

   top_rr_pick #(.num_req_p(num_req_p), .idx_w_p(idx_w)) u_pick (
      .req_i(req_valid_i),
      .ptr_i(ptr_q),
      .gnt_o(pick)
   );

   always_comb begin
      sel_data = '0;
      gidx = '0;
      for (int i = 0; i < num_req_p; i++)
         if (grant_q[i]) begin
            sel_data = req_data_i[i];
            gidx = idx_w'(i);
         end
   end

   // the owner may push whenever the output register has room or is draining this cycle
   assign req_accept_o = (state_q == ST_LOCK && (!kv_q || key_accept_i)) ? grant_q : '0;
   assign xfer = |(req_valid_i & req_accept_o);
   assign last_beat = |(req_last_i & grant_q);
   assign done = xfer && (last_beat || cnt_q + 1'b1 == cnt_wl'(max_burst_p));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (state_q == ST_IDLE) begin
         if (|req_valid_i) begin
            state_d = ST_LOCK;
            grant_d = pick;
         end
      end else if (done) begin
         state_d = ST_IDLE;
         grant_d = '0;
         cnt_d = '0;
         ptr_d = (gidx == idx_w'(num_req_p - 1)) ? '0 : gidx + 1'b1;
      end else if (xfer) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // output register drains regardless of arbiter state
   assign kv_d = xfer || (kv_q && !key_accept_i);
   assign kd_d = xfer ? sel_data : kd_q;

   always_ff @(posedge main_clk_i) begin
      if (main_rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q <= '0;
         cnt_q <= '0;
         kv_q <= 1'b0;
         kd_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         kv_q <= kv_d;
         kd_q <= kd_d;
      end
   end

   assign key_valid_o = kv_q;
   assign key_data_o = kd_q;
   assign grant_o = grant_q;
   assign busy_o = (state_q == ST_LOCK) || kv_q;
endmodule
